// File: rtl/dynamic_branch_predictor.sv
// Fetch-stage branch predictor: 16 x 2-bit saturating-counter BHT plus 16 x 16-bit BTB,
// combinational lookup, decode-stage update. Optional macro DBP_WRITE_BYPASS_EN forwards same-index writes.
module dynamic_branch_predictor (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  PC_curr,
    input  logic [3:0]  IF_ID_PC_curr,
    input  logic [1:0]  IF_ID_prediction,
    input  logic        enable,
    input  logic        was_branch,
    input  logic        actual_taken,
    input  logic [15:0] actual_target,
    input  logic        branch_mispredicted,
    output logic [1:0]  prediction,
    output logic [15:0] predicted_target
);

    logic [1:0]  bht_q [16];
    logic [1:0]  bht_d [16];
    logic [15:0] btb_q [16];
    logic [15:0] btb_d [16];

    logic        bht_wr_s;
    logic        btb_wr_s;
    logic [1:0]  new_ctr_s;

    function automatic logic [1:0] next_counter(input logic [1:0] cur, input logic taken);
        logic [1:0] res;
        res = cur;
        case ({taken, cur})
            3'b1_11: res = 2'b11;
            3'b0_00: res = 2'b00;
            default: res = taken ? (cur + 2'd1) : (cur - 2'd1);
        endcase
        return res;
    endfunction

    // Update qualification; the counter is advanced from the pipelined prediction, not a table re-read
    always_comb begin
        bht_wr_s  = enable && was_branch;
        btb_wr_s  = bht_wr_s && actual_taken && branch_mispredicted;
        new_ctr_s = next_counter(IF_ID_prediction, actual_taken);
    end

    // Next-state for both tables
    always_comb begin
        bht_d = bht_q;
        btb_d = btb_q;
        if (bht_wr_s) begin
            bht_d[IF_ID_PC_curr] = new_ctr_s;
        end else begin
            bht_d = bht_q;
        end
        if (btb_wr_s) begin
            btb_d[IF_ID_PC_curr] = actual_target;
        end else begin
            btb_d = btb_q;
        end
    end

    // Table storage with synchronous reset taking priority over updates
    always_ff @(posedge clk) begin
        if (rst) begin
            bht_q <= '{default: 2'b00};
            btb_q <= '{default: 16'h0000};
        end else begin
            bht_q <= bht_d;
            btb_q <= btb_d;
        end
    end

    // Combinational lookup
    always_comb begin
        prediction       = bht_q[PC_curr];
        predicted_target = btb_q[PC_curr];
`ifdef DBP_WRITE_BYPASS_EN
        if (bht_wr_s && (PC_curr == IF_ID_PC_curr)) begin
            prediction = new_ctr_s;
            if (btb_wr_s) begin
                predicted_target = actual_target;
            end else begin
                predicted_target = btb_q[PC_curr];
            end
        end else begin
            prediction       = bht_q[PC_curr];
            predicted_target = btb_q[PC_curr];
        end
`else
        if (1'b0) begin
            prediction = 2'b00;
        end else begin
            prediction = bht_q[PC_curr];
        end
`endif
    end

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Self-checking bench for dynamic_branch_predictor: directed vector table, corner sequences,
// and randomized traffic against an array-based reference model.
module tb_dynamic_branch_predictor;

    logic        clk;
    logic        rst;
    logic [3:0]  PC_curr;
    logic [3:0]  IF_ID_PC_curr;
    logic [1:0]  IF_ID_prediction;
    logic        enable;
    logic        was_branch;
    logic        actual_taken;
    logic [15:0] actual_target;
    logic        branch_mispredicted;
    logic [1:0]  prediction;
    logic [15:0] predicted_target;

    int checks;
    int failures;

    dynamic_branch_predictor dut (
        .clk                 (clk),
        .rst                 (rst),
        .PC_curr             (PC_curr),
        .IF_ID_PC_curr       (IF_ID_PC_curr),
        .IF_ID_prediction    (IF_ID_prediction),
        .enable              (enable),
        .was_branch          (was_branch),
        .actual_taken        (actual_taken),
        .actual_target       (actual_target),
        .branch_mispredicted (branch_mispredicted),
        .prediction          (prediction),
        .predicted_target    (predicted_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ipc;
        logic [1:0]  pin;
        logic        en;
        logic        wb;
        logic        tk;
        logic        mis;
        logic [15:0] tgt;
        logic [3:0]  lpc;
        logic [1:0]  epred;
        logic [15:0] etgt;
    } vec_t;

    vec_t vecs[$];

    int model_bht [16];
    int model_btb [16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] ipc, input logic [1:0] pin, input logic en, input logic wb,
                       input logic tk, input logic mis, input logic [15:0] tgt, input logic [3:0] lpc,
                       input logic [1:0] epred, input logic [15:0] etgt);
        vec_t v;
        v = '{ipc, pin, en, wb, tk, mis, tgt, lpc, epred, etgt};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] pc, input logic [3:0] ipc, input logic [1:0] pin,
                         input logic en, input logic wb, input logic tk, input logic mis,
                         input logic [15:0] tgt);
        PC_curr             = pc;
        IF_ID_PC_curr       = ipc;
        IF_ID_prediction    = pin;
        enable              = en;
        was_branch          = wb;
        actual_taken        = tk;
        branch_mispredicted = mis;
        actual_target       = tgt;
    endtask

    // Clock the staged update in, then idle the update port so lookups show stored state
    task automatic step_and_idle();
        @(posedge clk);
        #1;
        enable     = 1'b0;
        was_branch = 1'b0;
        #1;
    endtask

    function automatic int model_next(input int c, input logic tk);
        if (tk) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        for (int k = 0; k < 3; k++) begin
            logic [3:0] pcs [3];
            pcs = '{4'h0, 4'h8, 4'hF};
            PC_curr = pcs[k];
            #1;
            chk($sformatf("reset_pred_pc%0h", pcs[k]), int'(prediction), 0);
            chk($sformatf("reset_tgt_pc%0h", pcs[k]), int'(predicted_target), 0);
        end

        // ipc pin en wb tk mis tgt lpc epred etgt
        add(4'h8, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0080, 4'h8, 2'b01, 16'h0080);
        add(4'h8, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0080, 4'h8, 2'b10, 16'h0080);
        add(4'h8, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0080, 4'h8, 2'b11, 16'h0080);
        add(4'h8, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0080, 4'h8, 2'b11, 16'h0080);
        add(4'h8, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'h8, 2'b10, 16'h0080);
        add(4'h5, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 4'h5, 2'b11, 16'h1234);
        add(4'h5, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 16'hBEEF, 4'h5, 2'b10, 16'h1234);
        add(4'h5, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 16'hBEEF, 4'h5, 2'b01, 16'h1234);
        add(4'h5, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 4'h5, 2'b00, 16'h1234);
        add(4'h5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 4'h5, 2'b00, 16'h1234);
        add(4'h5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 16'hBEEF, 4'h5, 2'b00, 16'h1234);
        add(4'h8, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 4'h8, 2'b10, 16'h0080);
        add(4'h5, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 4'h5, 2'b00, 16'h1234);
        add(4'h2, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0999, 4'h2, 2'b01, 16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].lpc, vecs[i].ipc, vecs[i].pin, vecs[i].en, vecs[i].wb,
                  vecs[i].tk, vecs[i].mis, vecs[i].tgt);
            step_and_idle();
            PC_curr = vecs[i].lpc;
            #1;
            chk($sformatf("vec%0d_pred", i), int'(prediction), int'(vecs[i].epred));
            chk($sformatf("vec%0d_tgt", i), int'(predicted_target), int'(vecs[i].etgt));
        end

        // Sweep every index: only 2, 5 and 8 may have changed
        for (int p = 0; p < 16; p++) begin
            int ep;
            int et;
            ep = (p == 8) ? 2 : (p == 2) ? 1 : 0;
            et = (p == 8) ? 32'h0080 : (p == 5) ? 32'h1234 : 0;
            PC_curr = 4'(p);
            #1;
            chk($sformatf("sweep_pred_pc%0d", p), int'(prediction), ep);
            chk($sformatf("sweep_tgt_pc%0d", p), int'(predicted_target), et);
        end

        // Same-cycle read/write of index 3
        drive(4'h3, 4'h3, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0333);
        #1;
`ifdef DBP_WRITE_BYPASS_EN
        chk("samecyc_pred", int'(prediction), 1);
        chk("samecyc_tgt", int'(predicted_target), 32'h0333);
`else
        chk("samecyc_pred", int'(prediction), 0);
        chk("samecyc_tgt", int'(predicted_target), 0);
`endif
        step_and_idle();
        chk("after_samecyc_pred", int'(prediction), 1);
        chk("after_samecyc_tgt", int'(predicted_target), 32'h0333);

        // Reset with a concurrent update: update is dropped, all tables cleared
        drive(4'h3, 4'h3, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 16'h7777);
        rst = 1'b1;
        step_and_idle();
        rst = 1'b0;
        #1;
        chk("rst_mid_pred_pc3", int'(prediction), 0);
        chk("rst_mid_tgt_pc3", int'(predicted_target), 0);
        PC_curr = 4'h8;
        #1;
        chk("rst_mid_pred_pc8", int'(prediction), 0);
        chk("rst_mid_tgt_pc8", int'(predicted_target), 0);

        // Randomized traffic against the reference model
        for (int p = 0; p < 16; p++) begin
            model_bht[p] = 0;
            model_btb[p] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            logic [3:0]  pc;
            logic [3:0]  ipc;
            logic [1:0]  pin;
            logic        en;
            logic        wb;
            logic        tk;
            logic        mis;
            logic [15:0] tgt;
            int          ep;
            int          et;
            pc  = 4'($urandom_range(0, 15));
            ipc = ($urandom_range(0, 3) == 0) ? pc : 4'($urandom_range(0, 15));
            pin = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(model_bht[ipc]);
            en  = ($urandom_range(0, 4) != 0);
            wb  = ($urandom_range(0, 3) != 0);
            tk  = 1'($urandom_range(0, 1));
            mis = 1'($urandom_range(0, 1));
            tgt = 16'($urandom);
            drive(pc, ipc, pin, en, wb, tk, mis, tgt);
            #1;
            ep = model_bht[pc];
            et = model_btb[pc];
`ifdef DBP_WRITE_BYPASS_EN
            if (en && wb && (pc == ipc)) begin
                ep = model_next(int'(pin), tk);
                if (tk && mis) et = int'(tgt);
            end
`endif
            chk($sformatf("rand%0d_pred", n), int'(prediction), ep);
            chk($sformatf("rand%0d_tgt", n), int'(predicted_target), et);
            if (en && wb) begin
                model_bht[ipc] = model_next(int'(pin), tk);
                if (tk && mis) model_btb[ipc] = int'(tgt);
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
